// File: rtl/cascade_counter_pkg.sv
// rtl/cascade_counter_pkg.sv - shared types and constants for cascade_counter
//
// Contents:
//   state_t   : RUN (counting) / SAT (secondary saturated, counters frozen)
//   DIR_UP    : sec_dir value that makes the secondary count up
//   DIR_DOWN  : sec_dir value that makes the secondary count down
package cascade_counter_pkg;

  typedef enum logic {
    RUN = 1'b0,
    SAT = 1'b1
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo counter 0..max with load and registered wrap strobe
//
// Ports:
//   clk, reset  : clock (rising edge), asynchronous active-high reset
//   en          : advance this cycle (caller gates this with its own run state)
//   load        : synchronous load, wins over en
//   load_val    : value taken on load
//   max         : terminal value; counter runs 0..max
//   count       : current value
//   wrap        : registered pulse, counter wrapped on the previous edge
//   step        : this edge will wrap (used to step a following counter)
module mod_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             step
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // >= rather than == so a loaded value beyond max wraps on the next
  // enabled edge instead of running the long way round.
  logic at_term;
  assign at_term = (count >= max);
  assign step    = en && !load && at_term;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= load_val;
      wrap  <= 1'b0;
    end else if (en) begin
      if (at_term) begin
        count <= '0;
        wrap  <= 1'b1;
      end else begin
        count <= count + ONE;
        wrap  <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/cascade_counter.sv
// rtl/cascade_counter.sv - two-stage cascaded counter, secondary steps per primary wrap
//
// Ports:
//   clk, reset    : clock (rising edge), asynchronous active-high reset
//   en            : advance primary this cycle
//   load          : synchronous load of both counters, leaves SAT
//   pri_load_val  : primary load value
//   sec_load_val  : secondary load value
//   pri_max       : primary terminal value (primary counts 0..pri_max)
//   sec_dir       : secondary direction, DIR_UP / DIR_DOWN
//   sec_sat       : 1 = secondary saturates at its bound, 0 = wraps
//   pri_count     : primary value
//   sec_count     : secondary value
//   pri_wrap      : registered pulse, primary wrapped on the previous edge
//   sec_wrap      : registered pulse, secondary wrapped on the previous edge
//   done          : high while saturated
module cascade_counter
  import cascade_counter_pkg::*;
#(
  parameter int                 WIDTH     = 4,
  parameter int                 SEC_WIDTH = 4,
  parameter logic [SEC_WIDTH-1:0] SEC_RESET = {SEC_WIDTH{1'b1}}
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 load,
  input  logic [WIDTH-1:0]     pri_load_val,
  input  logic [SEC_WIDTH-1:0] sec_load_val,
  input  logic [WIDTH-1:0]     pri_max,
  input  logic                 sec_dir,
  input  logic                 sec_sat,
  output logic [WIDTH-1:0]     pri_count,
  output logic [SEC_WIDTH-1:0] sec_count,
  output logic                 pri_wrap,
  output logic                 sec_wrap,
  output logic                 done
);

  localparam logic [SEC_WIDTH-1:0] SEC_ONE = SEC_WIDTH'(1);

  state_t               state, state_next;
  logic [SEC_WIDTH-1:0] sec_next;
  logic                 sec_wrap_next;
  logic                 pri_en;
  logic                 pri_step;
  logic                 at_bound;

  // In SAT the primary is frozen too, so its enable is gated by the state.
  assign pri_en = en && (state == RUN);

  mod_counter #(
    .WIDTH (WIDTH)
  ) u_pri (
    .clk      (clk),
    .reset    (reset),
    .en       (pri_en),
    .load     (load),
    .load_val (pri_load_val),
    .max      (pri_max),
    .count    (pri_count),
    .wrap     (pri_wrap),
    .step     (pri_step)
  );

  assign at_bound = (sec_dir == DIR_UP) ? (&sec_count) : (sec_count == '0);

  always_comb begin
    state_next    = state;
    sec_next      = sec_count;
    sec_wrap_next = 1'b0;
    if (load) begin
      state_next = RUN;
      sec_next   = sec_load_val;
    end else if (pri_step) begin
      if (!at_bound) begin
        sec_next = (sec_dir == DIR_UP) ? sec_count + SEC_ONE : sec_count - SEC_ONE;
      end else if (sec_sat) begin
        state_next = SAT;
      end else begin
        sec_next      = (sec_dir == DIR_UP) ? '0 : {SEC_WIDTH{1'b1}};
        sec_wrap_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      sec_count <= SEC_RESET;
      sec_wrap  <= 1'b0;
    end else begin
      state     <= state_next;
      sec_count <= sec_next;
      sec_wrap  <= sec_wrap_next;
    end
  end

  // done is a decode of the state register, so it stays a registered output.
  assign done = (state == SAT);

endmodule

// File: doc/cascade_counter.md
# cascade_counter

Parametrised two-stage cascaded counter. A primary modulo counter advances on enable, and a secondary counter steps once per primary wrap in a run-time selectable direction, with wrap or saturate behaviour. It sits in the basic counter library as the general replacement for fixed-width up/down counter pairs: timers, prescalers and event dividers.

## Interface
Parameters:
- `WIDTH`, 4: primary counter width.
- `SEC_WIDTH`, 4: secondary counter width.
- `SEC_RESET`, all ones (`{SEC_WIDTH{1'b1}}`): secondary value on reset.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `en`  in  1  advance primary this cycle.
- `load`  in  1  synchronous load of both counters.
- `pri_load_val`  in  WIDTH  primary load value.
- `sec_load_val`  in  SEC_WIDTH  secondary load value.
- `pri_max`  in  WIDTH  primary terminal value; primary counts 0..`pri_max`.
- `sec_dir`  in  1  secondary direction, 1 = up, 0 = down.
- `sec_sat`  in  1  1 = saturate at bound, 0 = wrap.
- `pri_count`  out  WIDTH  primary value.
- `sec_count`  out  SEC_WIDTH  secondary value.
- `pri_wrap`  out  1  registered pulse: primary wrapped on previous edge.
- `sec_wrap`  out  1  registered pulse: secondary wrapped on previous edge.
- `done`  out  1  high while in SAT.

## Operation
- Reset values: `pri_count` = 0, `sec_count` = `SEC_RESET`, `pri_wrap` = 0, `sec_wrap` = 0, `done` = 0, state RUN.
- Priority per edge: `reset` > `load` > `en`.
- `load`:
  - `pri_count` ← `pri_load_val`, `sec_count` ← `sec_load_val`.
  - State ← RUN; `done` ← 0; both wrap pulses ← 0.
  - Legal in any state.
- Primary, in RUN with `en` = 1:
  - If `pri_count` >= `pri_max`: `pri_count` ← 0 and `pri_wrap` ← 1. This is a wrap, and it issues a secondary step.
  - Otherwise: `pri_count` + 1.
  - The >= compare makes a loaded value above `pri_max` wrap on the next enabled edge.
- `pri_max` = 0: primary holds 0 and every enabled edge is a wrap.
- Secondary step:
  - Bound is all ones when `sec_dir` = 1 and 0 when `sec_dir` = 0.
  - `sec_dir` and `sec_sat` are sampled on the step edge.
  - Not at bound: ±1.
  - At bound with `sec_sat` = 0: wrap to the opposite extreme and pulse `sec_wrap`.
  - At bound with `sec_sat` = 1: hold, state ← SAT, `done` ← 1. `pri_count` still wraps to 0 on that edge.
- State machine:
  - RUN → SAT on a saturating step.
  - SAT → RUN only on `load`.
  - In SAT both counters hold regardless of `en`, and wrap pulses stay 0.
- `en` = 0: everything holds and wrap pulses drop to 0.
- Wrap pulses last exactly one cycle unless the next edge wraps again. With `pri_max` = 0 and `en` held high, `pri_wrap` stays high continuously.
- Arithmetic is modulo 2^width. No overflow outputs beyond the wrap pulses.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Latency: a primary wrap and the resulting secondary step both appear one edge after the enabled edge at which `pri_count` >= `pri_max`.
- Reset mid-operation clears all outputs immediately, without a clock edge. Counting resumes on the first edge after deassertion.
- `load` and `en` in the same cycle: load wins, with no increment.
- Changing `pri_max` mid-count takes effect on the next edge's compare.

## Structure
- Package `cascade_counter_pkg`:
  - State enum `{RUN, SAT}`.
  - Direction constants `DIR_UP` = 1, `DIR_DOWN` = 0.
- Sub-module `mod_counter`: primary counter with `en`, `load`, terminal compare and wrap strobe, parametrised by `WIDTH`.
- Top level holds the secondary counter, bound logic, FSM and output pulse registers.

## Test plan
All scenarios use WIDTH = 4 and SEC_WIDTH = 4.
1. Reset, then `pri_max` = 12, `sec_dir` = 0, `sec_sat` = 0, `en` = 1 for 13 edges → `pri_count` = 0, `sec_count` = 14, `pri_wrap` = 1 for one cycle. After 26 edges, `sec_count` = 13.
2. Load pri = 0, sec = 1; `pri_max` = 0, `sec_dir` = 0, `sec_sat` = 1, `en` = 1:
   - Edge 1 → `sec_count` = 0.
   - Edge 2 → `sec_count` = 0, `done` = 1.
   - 5 further edges → unchanged.
   - Then `load` → `done` = 0.
3. Load sec = 15, `sec_dir` = 1, `sec_sat` = 0, `pri_max` = 0, `en` = 1 → after 1 edge `sec_count` = 0 and `sec_wrap` = 1 for one cycle.
4. `load` = 1 and `en` = 1 in the same cycle with `pri_load_val` = 7 → `pri_count` = 7, no increment. Load pri = 14 with `pri_max` = 5, then 1 enabled edge → `pri_count` = 0, `pri_wrap` = 1.
5. Mid-count (`pri_count` = 9), assert `reset` between edges → all outputs return to reset values immediately. With `en` high, after deassertion plus 1 edge → `pri_count` = 1.
6. Toggle `en` 1,0,1,0 with `pri_max` = 3 → `pri_count` advances only on enabled edges. `pri_wrap` appears only after the 4th enabled edge.
